eth_phy_10g_link_ctrl: RTL and testbench

ETH_PHY_10G_LINK_CTRL -- requirements
Module: eth_phy_10g_link_ctrl

---
 rtl/eth_phy_10g_pkg.sv | 33 +++
 rtl/eth_phy_link_timer.sv | 27 ++
 rtl/eth_phy_10g_link_ctrl.sv | 160 ++++++++++++++++
 tb/tb_eth_phy_10g_link_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared types, widths and saturating helpers
// for the 10G PHY receive link controller.
package eth_phy_10g_pkg;

  localparam int TIMER_W = 16;
  localparam int CNT_W   = 8;
  localparam int ACC_W   = 16;
  localparam int ERR_W   = 7;

  typedef enum logic [2:0] {
    ST_SERDES_RST  = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_WAIT_STABLE = 3'd2,
    ST_LINK_UP     = 3'd3,
    ST_PRBS        = 3'd4
  } link_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ERR_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W+1-ERR_W){1'b0}}, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/eth_phy_link_timer.sv
// 16-bit cycle timer with synchronous clear,
// count enable and saturation at all-ones.
module eth_phy_link_timer
  import eth_phy_10g_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [TIMER_W-1:0] o_count
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !(&r_count)) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10G PHY receive link bring-up FSM and counters.
// Define ETH_PHY_LINK_PRBS_EN to build the PRBS31 test state.
module eth_phy_10g_link_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int SERDES_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT      = 1024,
  parameter int STABLE_CYCLES     = 64
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic             rx_block_lock,
  input  logic             rx_high_ber,
  input  logic             rx_status,
  input  logic             serdes_rx_reset_req,
  input  logic [ERR_W-1:0] rx_error_count,
  input  logic             prbs_test_req,
  output logic             serdes_rx_reset,
  output logic             link_up,
  output logic [2:0]       link_state,
  output logic             cfg_tx_prbs31_enable,
  output logic             cfg_rx_prbs31_enable,
  output logic [CNT_W-1:0] flap_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [ACC_W-1:0] prbs_err_acc
);

  localparam logic [TIMER_W-1:0] RST_LAST =
    TIMER_W'(SERDES_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST =
    TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STB_LAST =
    TIMER_W'(STABLE_CYCLES - 1);

  link_state_e        r_state;
  link_state_e        w_next;
  logic [TIMER_W-1:0] w_timer;
  logic               w_timer_clr;
  logic               w_hold_clr;
  logic               w_tmo_inc;
  logic               w_flap_inc;
  logic [CNT_W-1:0]   r_flap;
  logic [CNT_W-1:0]   r_tmo;

  eth_phy_link_timer u_timer (
    .clk     (rx_clk),
    .rst_n   (rx_rst_n),
    .i_clr   (w_timer_clr),
    .i_en    (1'b1),
    .o_count (w_timer)
  );

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state <= ST_SERDES_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // A PCS reset request outranks every other transition.
  always_comb begin
    w_next     = r_state;
    w_hold_clr = 1'b0;
    w_tmo_inc  = 1'b0;
    w_flap_inc = 1'b0;
    if (r_state != ST_SERDES_RST && serdes_rx_reset_req) begin
      w_next = ST_SERDES_RST;
    end else begin
      case (r_state)
        ST_SERDES_RST: begin
          if (w_timer == RST_LAST) begin
            w_next = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (rx_block_lock) begin
            w_next = ST_WAIT_STABLE;
          end else if (w_timer == TMO_LAST) begin
            w_next    = ST_SERDES_RST;
            w_tmo_inc = 1'b1;
          end
        end
        ST_WAIT_STABLE: begin
          if (!rx_block_lock) begin
            w_next = ST_WAIT_LOCK;
          end else if (rx_high_ber || !rx_status) begin
            w_hold_clr = 1'b1;
          end else if (w_timer == STB_LAST) begin
            w_next = ST_LINK_UP;
          end
        end
        ST_LINK_UP: begin
          if (!rx_block_lock || rx_high_ber) begin
            w_next     = ST_WAIT_LOCK;
            w_flap_inc = 1'b1;
          end
`ifdef ETH_PHY_LINK_PRBS_EN
          else if (prbs_test_req) begin
            w_next = ST_PRBS;
          end
`endif
        end
`ifdef ETH_PHY_LINK_PRBS_EN
        ST_PRBS: begin
          if (!prbs_test_req) begin
            w_next = ST_SERDES_RST;
          end
        end
`endif
        default: w_next = ST_SERDES_RST;
      endcase
    end
  end

  assign w_timer_clr = (w_next != r_state) | w_hold_clr;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_flap <= '0;
      r_tmo  <= '0;
    end else begin
      if (w_flap_inc) r_flap <= sat_inc(r_flap);
      if (w_tmo_inc)  r_tmo  <= sat_inc(r_tmo);
    end
  end

`ifdef ETH_PHY_LINK_PRBS_EN
  logic [ACC_W-1:0] r_acc;

  // Cleared on the entry edge, accumulates while resident.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_acc <= '0;
    end else if (r_state != ST_PRBS && w_next == ST_PRBS) begin
      r_acc <= '0;
    end else if (r_state == ST_PRBS) begin
      r_acc <= sat_add(r_acc, rx_error_count);
    end
  end

  assign cfg_tx_prbs31_enable = (r_state == ST_PRBS);
  assign cfg_rx_prbs31_enable = (r_state == ST_PRBS);
  assign prbs_err_acc         = r_acc;
`else
  logic w_unused_prbs;

  assign w_unused_prbs        = ^{prbs_test_req, rx_error_count};
  assign cfg_tx_prbs31_enable = 1'b0;
  assign cfg_rx_prbs31_enable = 1'b0;
  assign prbs_err_acc         = '0;
`endif

  assign serdes_rx_reset = (r_state == ST_SERDES_RST);
  assign link_up         = (r_state == ST_LINK_UP);
  assign link_state      = r_state;
  assign flap_count      = r_flap;
  assign timeout_count   = r_tmo;

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Self-checking bench for eth_phy_10g_link_ctrl
// (default parameters; follows ETH_PHY_LINK_PRBS_EN).
module tb_eth_phy_10g_link_ctrl;

  localparam int RSTC = 16;
  localparam int TMO  = 1024;
  localparam int STB  = 64;
`ifdef ETH_PHY_LINK_PRBS_EN
  localparam bit PRBS_EN = 1'b1;
`else
  localparam bit PRBS_EN = 1'b0;
`endif

  logic       rx_clk = 1'b0;
  logic       rx_rst_n = 1'b1;
  logic       rx_block_lock = 1'b1;
  logic       rx_high_ber = 1'b0;
  logic       rx_status = 1'b1;
  logic       serdes_rx_reset_req = 1'b0;
  logic [6:0] rx_error_count = '0;
  logic       prbs_test_req = 1'b0;
  logic       serdes_rx_reset;
  logic       link_up;
  logic [2:0] link_state;
  logic       cfg_tx_prbs31_enable;
  logic       cfg_rx_prbs31_enable;
  logic [7:0] flap_count;
  logic [7:0] timeout_count;
  logic [15:0] prbs_err_acc;

  always #5 rx_clk = ~rx_clk;

  eth_phy_10g_link_ctrl #(
    .SERDES_RST_CYCLES (RSTC),
    .LOCK_TIMEOUT      (TMO),
    .STABLE_CYCLES     (STB)
  ) dut (
    .rx_clk               (rx_clk),
    .rx_rst_n             (rx_rst_n),
    .rx_block_lock        (rx_block_lock),
    .rx_high_ber          (rx_high_ber),
    .rx_status            (rx_status),
    .serdes_rx_reset_req  (serdes_rx_reset_req),
    .rx_error_count       (rx_error_count),
    .prbs_test_req        (prbs_test_req),
    .serdes_rx_reset      (serdes_rx_reset),
    .link_up              (link_up),
    .link_state           (link_state),
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
    .cfg_rx_prbs31_enable (cfg_rx_prbs31_enable),
    .flap_count           (flap_count),
    .timeout_count        (timeout_count),
    .prbs_err_acc         (prbs_err_acc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: state number, dwell time in that
  // state and event tallies, stepped once per clock.
  int m_state = 0;
  int m_t = 0;
  int m_flap = 0;
  int m_tmo = 0;
  int m_acc = 0;

  function automatic int lim(input int v, input int top);
    return (v > top) ? top : v;
  endfunction

  function automatic void mdl_step(
    input int st, input int t, input int fl, input int to,
    input int ac, output int nst, output int nt,
    output int nfl, output int nto, output int nac);
    bit clr;
    clr = 1'b0;
    nst = st; nfl = fl; nto = to; nac = ac;
    if (st != 0 && serdes_rx_reset_req) nst = 0;
    else if (st == 0) begin
      if (t == RSTC - 1) nst = 1;
    end else if (st == 1) begin
      if (rx_block_lock) nst = 2;
      else if (t == TMO - 1) begin
        nst = 0;
        nto = lim(to + 1, 255);
      end
    end else if (st == 2) begin
      if (!rx_block_lock) nst = 1;
      else if (rx_high_ber || !rx_status) clr = 1'b1;
      else if (t == STB - 1) nst = 3;
    end else if (st == 3) begin
      if (!rx_block_lock || rx_high_ber) begin
        nst = 1;
        nfl = lim(fl + 1, 255);
      end else if (PRBS_EN && prbs_test_req) nst = 4;
    end else if (st == 4) begin
      if (!prbs_test_req) nst = 0;
    end else nst = 0;
    if (st == 4) nac = lim(ac + int'(rx_error_count), 65535);
    if (nst == 4 && st != 4) nac = 0;
    nt = (nst != st || clr) ? 0 : lim(t + 1, 65535);
  endfunction

  always @(posedge rx_clk or negedge rx_rst_n) begin : mdl
    int ns, nt, nf, no, na;
    if (!rx_rst_n) begin
      m_state <= 0; m_t <= 0; m_flap <= 0;
      m_tmo <= 0; m_acc <= 0;
    end else begin
      mdl_step(m_state, m_t, m_flap, m_tmo, m_acc,
               ns, nt, nf, no, na);
      m_state <= ns; m_t <= nt; m_flap <= nf;
      m_tmo <= no; m_acc <= na;
    end
  end

  always @(negedge rx_clk) begin : cmp
    logic [38:0] act, exp;
    act = {serdes_rx_reset, link_up, link_state,
           cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
           flap_count, timeout_count, prbs_err_acc};
    exp = {m_state == 0, m_state == 3, 3'(m_state),
           m_state == 4, m_state == 4,
           8'(m_flap), 8'(m_tmo), 16'(m_acc)};
    chk("cycle", longint'(act), longint'(exp));
  end

  task automatic wait_up(input bit glitch, output int k);
    k = 0;
    while (!link_up && k < 400) begin
      if (glitch && k == 11) rx_status = 1'b0;
      if (glitch && k == 12) rx_status = 1'b1;
      @(negedge rx_clk);
      k++;
    end
  endtask

  task automatic wait_wl(output int k);
    k = 0;
    while (link_state != 3'd1 && k < 2000) begin
      @(negedge rx_clk);
      k++;
    end
  endtask

  initial begin : stim
    int k, cnt, rises;
    logic prev;
    int rt[3];
    #1 rx_rst_n = 1'b0;
    repeat (3) @(negedge rx_clk);
    chk("rst_serdes", serdes_rx_reset, 1);
    chk("rst_state", link_state, 0);
    chk("rst_linkup", link_up, 0);
    chk("rst_flap", flap_count, 0);

    rx_rst_n = 1'b1;
    cnt = 0;
    while (serdes_rx_reset && cnt < 40) begin
      cnt++;
      @(negedge rx_clk);
    end
    chk("rst_pulse_len", cnt, 16);
    chk("wl_entry", link_state, 1);
    wait_up(1'b0, k);
    chk("first_up_delay", k, 65);
    chk("first_up_state", link_state, 3);

    serdes_rx_reset_req = 1'b1;
    rx_block_lock = 1'b0;
    @(negedge rx_clk);
    chk("req_beats_loss", link_state, 0);
    chk("req_no_flap", flap_count, 0);
    serdes_rx_reset_req = 1'b0;
    rx_block_lock = 1'b1;
    wait_wl(k);
    chk("rerst_len", k, 16);
    wait_up(1'b1, k);
    chk("glitch_up_delay", k, 76);

    for (int i = 0; i < 300; i++) begin
      rx_high_ber = 1'b1;
      @(negedge rx_clk);
      rx_high_ber = 1'b0;
      chk("flap_to_wl", link_state, 1);
      if (i == 0) chk("flap_first", flap_count, 1);
      wait_up(1'b0, k);
      chk("flap_relink", k, 65);
    end
    chk("flap_sat", flap_count, 255);

    rx_error_count = 7'd100;
    prbs_test_req = 1'b1;
    @(negedge rx_clk);
`ifdef ETH_PHY_LINK_PRBS_EN
    chk("prbs_entry", link_state, 4);
    chk("prbs_tx_en", cfg_tx_prbs31_enable, 1);
    repeat (699) @(negedge rx_clk);
    chk("prbs_acc_sat", prbs_err_acc, 16'hFFFF);
    chk("prbs_rx_en", cfg_rx_prbs31_enable, 1);
    prbs_test_req = 1'b0;
    @(negedge rx_clk);
    chk("prbs_exit", link_state, 0);
    chk("prbs_acc_hold", prbs_err_acc, 16'hFFFF);
    wait_wl(k);
    wait_up(1'b0, k);
    rx_error_count = 7'd3;
    prbs_test_req = 1'b1;
    @(negedge rx_clk);
    chk("prbs_reentry_clr", prbs_err_acc, 0);
    @(negedge rx_clk);
    chk("prbs_acc_step", prbs_err_acc, 3);
    chk("prbs_mid_state", link_state, 4);
`else
    chk("noprbs_stay", link_state, 3);
    chk("noprbs_tx_en", cfg_tx_prbs31_enable, 0);
    repeat (699) @(negedge rx_clk);
    chk("noprbs_acc", prbs_err_acc, 0);
    chk("noprbs_up", link_up, 1);
    prbs_test_req = 1'b0;
    @(negedge rx_clk);
`endif
    #2 rx_rst_n = 1'b0;
    #1;
    chk("async_serdes", serdes_rx_reset, 1);
    chk("async_linkup", link_up, 0);
    chk("async_state", link_state, 0);
    chk("async_prbs", {cfg_tx_prbs31_enable,
                       cfg_rx_prbs31_enable}, 0);
    chk("async_cnts", {flap_count, timeout_count,
                       prbs_err_acc}, 0);

    prbs_test_req = 1'b0;
    rx_error_count = '0;
    rx_block_lock = 1'b0;
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    prev = serdes_rx_reset;
    rises = 0;
    rt = '{0, 0, 0};
    for (int j = 1; j <= 3200 && rises < 3; j++) begin
      @(negedge rx_clk);
      if (serdes_rx_reset && !prev) begin
        rt[rises] = j;
        rises++;
      end
      prev = serdes_rx_reset;
    end
    chk("tmo_rises", rises, 3);
    chk("tmo_t0", rt[0], 1040);
    chk("tmo_t1", rt[1], 2080);
    chk("tmo_t2", rt[2], 3120);
    chk("tmo_count", timeout_count, 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
